// File: rtl/my_ram_n.sv
// rtl/my_ram_n.sv - parametrised WIDTH x DEPTH synchronous RAM with registered read and clear sequencer
//
// Purpose:
//   Leaf storage bank with one write port and one registered read port.
//   After reset, or on a clr pulse, a sequencer zeroes every word, one per
//   cycle. Accesses are ignored while it runs.
//
// Build option:
//   MY_RAM_N_BYPASS_EN defined   -> a read and a write to the same address
//                                   in one cycle return the new data (write-first).
//   MY_RAM_N_BYPASS_EN undefined -> the same case returns the old word (read-first).
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   clr       in   request a full-array clear (pulse)
//   wr_en     in   write strobe
//   wr_addr   in   [ADDR_W] write address
//   wr_data   in   [WIDTH]  write data
//   rd_en     in   read strobe
//   rd_addr   in   [ADDR_W] read address
//   rd_data   out  [WIDTH]  registered read data
//   rd_valid  out  rd_data was updated by a read this cycle
//   busy      out  clear sequencer active; accesses ignored

module my_ram_n #(
    parameter int  WIDTH  = 16,
    parameter int  DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              busy
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    // One extra bit so DEPTH itself is representable when DEPTH is a power of 2.
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] clr_idx_nxt;
    logic              busy_nxt;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              rd_fire;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              collide;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
    assign collide     = wr_en && wr_in_range && (wr_addr == rd_addr);

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        mem_we      = 1'b0;
        mem_waddr   = wr_addr;
        mem_wdata   = wr_data;
        rd_fire     = 1'b0;

        case (state)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx;
                mem_wdata = '0;
                if (clr_idx == LAST_IDX) begin
                    state_nxt   = S_RUN;
                    clr_idx_nxt = '0;
                end else begin
                    clr_idx_nxt = clr_idx + ADDR_W'(1);
                end
            end
            S_RUN: begin
                mem_we  = wr_en && wr_in_range;
                rd_fire = rd_en;
            end
            default: begin
                state_nxt   = S_CLEAR;
                clr_idx_nxt = '0;
            end
        endcase

        // A clear request always restarts the sweep from word 0.
        if (clr) begin
            state_nxt   = S_CLEAR;
            clr_idx_nxt = '0;
        end

        busy_nxt = (state_nxt == S_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_CLEAR;
            clr_idx  <= '0;
            busy     <= 1'b1;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_nxt;
            clr_idx  <= clr_idx_nxt;
            busy     <= busy_nxt;
            rd_valid <= rd_fire;
            if (rd_fire) begin
                if (!rd_in_range) begin
                    rd_data <= '0;
                end else begin
`ifdef MY_RAM_N_BYPASS_EN
                    rd_data <= collide ? wr_data : mem[rd_addr];
`else
                    rd_data <= mem[rd_addr];
`endif
                end
            end
        end
    end

`ifndef MY_RAM_N_BYPASS_EN
    // Read-first: the collision flag has no consumer in this build.
    logic unused_collide;
    assign unused_collide = collide;
`endif

    // Storage has no reset of its own; the sequencer zeroes it.
    // Writes are suppressed on reset edges so the sweep always starts clean.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_my_ram_n.sv
// tb/tb_my_ram_n.sv - randomized self-checking bench for my_ram_n (DEPTH 8 and DEPTH 5)

module tb_my_ram_n;

    localparam int W = 16;
    localparam int AW = 3;

`ifdef MY_RAM_N_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    logic [W-1:0]  rd_data8, rd_data5;
    logic          rd_valid8, rd_valid5;
    logic          busy8, busy5;

    always #5 clk = ~clk;

    my_ram_n #(.WIDTH(W), .DEPTH(8)) u_ram8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data8),
        .rd_valid (rd_valid8),
        .busy     (busy8)
    );

    my_ram_n #(.WIDTH(W), .DEPTH(5)) u_ram5 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data5),
        .rd_valid (rd_valid5),
        .busy     (busy5)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: index 0 is the DEPTH=8 bank, index 1 the DEPTH=5 bank.
    // A clear is modelled as "whole array zero, busy for DEPTH more edges".
    logic [W-1:0] m_mem   [2][8];
    int           m_left  [2];
    logic         m_valid [2];
    logic [W-1:0] m_data  [2];

    function automatic int dep_of(input int d);
        return (d == 0) ? 8 : 5;
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int dep;
            dep = dep_of(d);
            if (!rst_n) begin
                m_left[d]  = dep;
                m_valid[d] = 1'b0;
                m_data[d]  = '0;
                for (int k = 0; k < 8; k++) m_mem[d][k] = '0;
            end else if (m_left[d] > 0) begin
                m_left[d]  = clr ? dep : m_left[d] - 1;
                m_valid[d] = 1'b0;
            end else begin
                m_valid[d] = rd_en;
                if (rd_en) begin
                    if (int'(rd_addr) >= dep)
                        m_data[d] = '0;
                    else if (BYP && wr_en && wr_addr == rd_addr)
                        m_data[d] = wr_data;
                    else
                        m_data[d] = m_mem[d][rd_addr];
                end
                if (wr_en && int'(wr_addr) < dep) m_mem[d][wr_addr] = wr_data;
                if (clr) begin
                    m_left[d] = dep;
                    for (int k = 0; k < 8; k++) m_mem[d][k] = '0;
                end
            end
        end
    endtask

    // One clock: model follows the edge, outputs are compared 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("busy8",  busy8,     m_left[0] > 0);
        chk("valid8", rd_valid8, m_valid[0]);
        chk("data8",  rd_data8,  m_data[0]);
        chk("busy5",  busy5,     m_left[1] > 0);
        chk("valid5", rd_valid5, m_valid[1]);
        chk("data5",  rd_data5,  m_data[1]);
    endtask

    task automatic idle();
        clr = 0; wr_en = 0; rd_en = 0;
    endtask

    // Counts cycles with busy high (bounded); optionally keeps a write to @1 pending.
    task automatic count_busy(input bit try_write, output int n8, output int n5);
        n8 = 0; n5 = 0;
        for (int i = 0; i < 40 && (busy8 || busy5); i++) begin
            if (busy8) n8++;
            if (busy5) n5++;
            if (try_write) begin
                wr_en = 1; wr_addr = 3'd1; wr_data = 16'hDEAD;
            end
            tick();
        end
        wr_en = 0;
    endtask

    int n8, n5;

    initial begin
        rst_n = 0; idle(); wr_addr = 0; wr_data = 0; rd_addr = 0;
        for (int d = 0; d < 2; d++) begin
            m_left[d] = 0; m_valid[d] = 0; m_data[d] = 0;
            for (int k = 0; k < 8; k++) m_mem[d][k] = 0;
        end

        // Reset then release: busy for DEPTH cycles, outputs zero.
        tick(); tick();
        chk("rst_busy", busy8, 1'b1);
        chk("rst_valid", rd_valid8, 1'b0);
        chk("rst_data", rd_data8, 16'h0);
        rst_n = 1;
        count_busy(1'b0, n8, n5);
        chk("rst_len8", n8, 8);
        chk("rst_len5", n5, 5);

        for (int a = 0; a < 8; a++) begin
            rd_en = 1; rd_addr = AW'(a);
            tick();
            chk("init_rd", rd_data8, 16'h0);
        end
        idle();

        // Basic write then back-to-back reads.
        wr_en = 1; wr_addr = 3; wr_data = 16'hA5A5; tick();
        wr_addr = 7; wr_data = 16'h1234; tick();
        wr_en = 0;
        rd_en = 1; rd_addr = 3; tick();
        chk("rd3", rd_data8, 16'hA5A5); chk("rd3_v", rd_valid8, 1'b1);
        rd_addr = 7; tick();
        chk("rd7", rd_data8, 16'h1234); chk("rd7_v", rd_valid8, 1'b1);
        rd_en = 0; tick();
        chk("rd_idle_v", rd_valid8, 1'b0);
        chk("rd_hold", rd_data8, 16'h1234);

        // Same-address collision.
        wr_en = 1; wr_addr = 2; wr_data = 16'h1111; tick();
        wr_data = 16'hBEEF; rd_en = 1; rd_addr = 2; tick();
        chk("collide", rd_data8, BYP ? 16'hBEEF : 16'h1111);
        wr_en = 0; tick();
        chk("collide_after", rd_data8, 16'hBEEF);
        idle();

        // Fill, clear from RUN, write during busy must be dropped.
        for (int a = 0; a < 8; a++) begin
            wr_en = 1; wr_addr = AW'(a); wr_data = 16'h0100 + 16'(a); tick();
        end
        idle();
        clr = 1; tick(); clr = 0;
        count_busy(1'b1, n8, n5);
        chk("clr_len8", n8, 8);
        chk("clr_len5", n5, 5);
        for (int a = 0; a < 8; a++) begin
            rd_en = 1; rd_addr = AW'(a); tick();
            chk("clr_rd", rd_data8, 16'h0);
        end
        idle();

        // Reset in the middle of a clear restarts it.
        clr = 1; tick(); clr = 0;
        tick(); tick(); tick();
        rst_n = 0; tick(); rst_n = 1;
        count_busy(1'b0, n8, n5);
        chk("mid_len8", n8, 8);
        chk("mid_len5", n5, 5);

        // Out-of-range access on the DEPTH=5 bank.
        for (int a = 0; a < 5; a++) begin
            wr_en = 1; wr_addr = AW'(a); wr_data = 16'h5000 + 16'(a); tick();
        end
        wr_addr = 6; wr_data = 16'hFFFF; tick();
        wr_en = 0;
        for (int a = 0; a < 5; a++) begin
            rd_en = 1; rd_addr = AW'(a); tick();
            chk("oor_keep", rd_data5, 16'h5000 + 16'(a));
        end
        rd_addr = 6; tick();
        chk("oor_rd", rd_data5, 16'h0);
        chk("oor_rd_v", rd_valid5, 1'b1);
        idle();

        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 600; i++) begin
            rst_n   = ($urandom_range(0, 199) != 0);
            clr     = ($urandom_range(0, 63) == 0);
            wr_en   = $urandom_range(0, 1);
            rd_en   = $urandom_range(0, 1);
            wr_addr = AW'($urandom_range(0, 7));
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 7));
            wr_data = W'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/my_ram_n.md
# my_ram_n

Parametrised synchronous RAM: generalises the fixed 8×16 register RAM to WIDTH×DEPTH storage. It has independent write and read ports and a registered read with a valid flag. A built-in clear sequencer zeroes every word after reset or on request. It sits below the larger RAM hierarchy as the leaf storage bank and replaces hand-instantiated register arrays.

## Interface
- WIDTH, 16, data word width in bits (≥1)
- DEPTH, 8, number of words (≥2, any integer)
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- clr  input  1  request full-array clear (pulse)
- wr_en  input  1  write strobe
- wr_addr  input  ADDR_W  write address
- wr_data  input  WIDTH  write data
- rd_en  input  1  read strobe
- rd_addr  input  ADDR_W  read address
- rd_data  output  WIDTH  registered read data
- rd_valid  output  1  rd_data updated this cycle
- busy  output  1  clear sequencer active; ports ignored

## Operation
- FSM states:
  - CLEAR: writes 0 to word clr_idx and increments clr_idx each cycle. Moves to RUN after writing DEPTH-1.
  - RUN: normal access.
- rst_n low at an edge: FSM→CLEAR, clr_idx→0, rd_data→0, rd_valid→0, busy→1. Memory words are not reset directly; the sequencer zeroes them.
- Reset mid-clear restarts the sequence at index 0.
- clr high in RUN: →CLEAR at index 0 next cycle. clr high in CLEAR: restart at index 0. rst_n low has priority over clr.
- busy = 1 exactly while in CLEAR.
- In CLEAR, wr_en and rd_en are ignored, rd_valid = 0, and rd_data holds its value.
- Write (RUN): wr_en high → mem[wr_addr] ← wr_data at the edge.
- Read (RUN): rd_en high → next cycle rd_data = mem[rd_addr] and rd_valid = 1. rd_en low → rd_valid = 0 and rd_data holds.
- Out-of-range address (addr ≥ DEPTH, non-power-of-2 DEPTH only):
  - write is dropped, no word changes;
  - read returns 0 with rd_valid = 1.
- Simultaneous write and read to different addresses: both complete independently.
- Same-address read and write in one cycle: result set by the Configuration section.

## Timing
- Read latency: 1 cycle from the rd_en edge to rd_data/rd_valid.
- Write visible to a read issued the following cycle or later.
- Clear duration: busy is high for exactly DEPTH cycles after the first edge with rst_n high, or after the edge that samples clr. The first RUN cycle can accept an access.
- Throughput: one write and one read per cycle in RUN.
- All outputs come directly from registers. No combinational path from inputs to outputs.

## Configuration
- MY_RAM_N_BYPASS_EN defined: same-cycle, same-address read and write returns the new wr_data on rd_data next cycle (write-first).
- MY_RAM_N_BYPASS_EN undefined: returns the old stored word (read-first).
- Either way, the memory word holds wr_data after the edge.

## Test plan
- Reset/clear: rst_n low 2 cycles then high (WIDTH=16, DEPTH=8) → busy=1 for 8 cycles, rd_data=0, rd_valid=0. Reading addresses 0–7 afterwards returns 0x0000.
- Write/read: write 0xA5A5 @3, 0x1234 @7; read 3 then 7 on consecutive cycles → rd_data 0xA5A5 then 0x1234, one cycle after each rd_en, rd_valid=1 each.
- Collision: write 0xBEEF @2 (holding 0x1111) with a same-cycle read @2 → 0xBEEF if MY_RAM_N_BYPASS_EN is defined, else 0x1111. A follow-up read returns 0xBEEF in both builds.
- clr in RUN: fill all words nonzero, pulse clr → busy high 8 cycles. A write @1 during busy is dropped; afterwards every address reads 0x0000.
- Reset mid-clear: assert rst_n low at clear cycle 4 for 1 cycle → sequence restarts, busy high a further 8 cycles from rst_n release.
- Non-power-of-2 (DEPTH=5): write 0xFFFF @6 → no word 0–4 changes; read @6 → 0x0000 with rd_valid=1.
